// File: rtl/shu_pkg.sv
// Shared definitions for the iterative shift unit: op codes, FSM states
// and the width of the remaining-shift counter.
package shu_pkg;

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_RRX = 3'd4;
    localparam logic [2:0] OP_LNK = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    // Counter must hold up to WIDTH+1.
    function automatic int shu_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/shu_step.sv
// One combinational pass of the shifter: moves {c,w} by k bits (k <= STEP)
// using single-bit steps so every op shares one carry rule.
module shu_step
    import shu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CW    = 5
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] w_i,
    input  logic             c_i,
    input  logic [CW-1:0]    k,
    output logic [WIDTH-1:0] w_o,
    output logic             c_o
);

    always_comb begin
        w_o = w_i;
        c_o = c_i;
        for (int i = 0; i < STEP; i++) begin
            if (CW'(i) < k) begin
                unique case (op)
                    OP_LSL: begin
                        c_o = w_o[WIDTH-1];
                        w_o = {w_o[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        c_o = w_o[0];
                        w_o = {1'b0, w_o[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        c_o = w_o[0];
                        w_o = {w_o[WIDTH-1], w_o[WIDTH-1:1]};
                    end
                    OP_ROR: begin
                        w_o = {w_o[0], w_o[WIDTH-1:1]};
                        c_o = w_o[WIDTH-1];
                    end
                    // Carry sits above the MSB and rotates with the word.
                    OP_RRX: begin
                        {c_o, w_o} = {w_o[0], c_o, w_o[WIDTH-1:1]};
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shu_iter.sv
// Multi-cycle shift unit: start/ready handshake, up to STEP bits per clock,
// registered result and NZCV flags presented with a one-cycle done pulse.
module shu_iter
    import shu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int BW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [BW-1:0]    b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             V
);

    localparam int CW = shu_cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             c_q, c_d;
    logic [CW-1:0]    n_q, n_d;
    logic [2:0]       op_q, op_d;
    logic             amsb_q, amsb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cf_q, cf_d, nf_q, nf_d, zf_q, zf_d, vf_q, vf_d;

    logic [CW-1:0]    k;
    logic [CW-1:0]    n_acc;
    logic [WIDTH-1:0] w_step;
    logic             c_step;
    logic [WIDTH:0]   lnk_sum;
    logic             ld;
    logic [WIDTH-1:0] ld_s;
    logic             ld_c, ld_v;

    assign k       = (n_q > CW'(STEP)) ? CW'(STEP) : n_q;
    assign lnk_sum = {1'b0, a} + (WIDTH+1)'(2);

    shu_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CW    (CW)
    ) u_step (
        .op  (op_q),
        .w_i (w_q),
        .c_i (c_q),
        .k   (k),
        .w_o (w_step),
        .c_o (c_step)
    );

    // Effective shift count, clamped so no op iterates past a fixed result.
    always_comb begin
        n_acc = '0;
        unique case (op)
            OP_LSL, OP_LSR:
                n_acc = (int'(b) > WIDTH + 1) ? CW'(WIDTH + 1) : CW'(b);
            OP_ASR:
                n_acc = (int'(b) > WIDTH) ? CW'(WIDTH) : CW'(b);
            OP_ROR:
                n_acc = CW'(int'(b) % WIDTH);
            OP_RRX:
                n_acc = CW'(int'(b) % (WIDTH + 1));
            default:
                n_acc = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        c_d     = c_q;
        n_d     = n_q;
        op_d    = op_q;
        amsb_d  = amsb_q;
        ld      = 1'b0;
        ld_s    = w_step;
        ld_c    = c_step;
        ld_v    = amsb_q ^ w_step[WIDTH-1];
        unique case (state_q)
            S_SHIFT: begin
                w_d = w_step;
                c_d = c_step;
                n_d = n_q - k;
                if (n_q == k) begin
                    state_d = S_DONE;
                    ld      = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d   = op;
                    w_d    = a;
                    c_d    = cin;
                    amsb_d = a[WIDTH-1];
                    n_d    = n_acc;
                    if (n_acc == '0) begin
                        state_d = S_DONE;
                        ld      = 1'b1;
                        unique case (op)
                            OP_LNK: begin
                                ld_s = lnk_sum[WIDTH-1:0];
                                ld_c = lnk_sum[WIDTH];
                                ld_v = ~a[WIDTH-1] & lnk_sum[WIDTH-1];
                            end
                            OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX: begin
                                ld_s = a;
                                ld_c = cin;
                                ld_v = 1'b0;
                            end
                            default: begin
                                ld_s = '0;
                                ld_c = 1'b0;
                                ld_v = 1'b0;
                            end
                        endcase
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
        endcase
    end

    always_comb begin
        s_d  = s_q;
        cf_d = cf_q;
        nf_d = nf_q;
        zf_d = zf_q;
        vf_d = vf_q;
        if (ld) begin
            s_d  = ld_s;
            cf_d = ld_c;
            nf_d = ld_s[WIDTH-1];
            zf_d = (ld_s == '0);
            vf_d = ld_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            c_q     <= 1'b0;
            n_q     <= '0;
            op_q    <= '0;
            amsb_q  <= 1'b0;
            s_q     <= '0;
            cf_q    <= 1'b0;
            nf_q    <= 1'b0;
            zf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            n_q     <= n_d;
            op_q    <= op_d;
            amsb_q  <= amsb_d;
            s_q     <= s_d;
            cf_q    <= cf_d;
            nf_q    <= nf_d;
            zf_q    <= zf_d;
            vf_q    <= vf_d;
        end
    end

    assign ready = (state_q != S_SHIFT);
    assign done  = (state_q == S_DONE);
    assign s     = s_q;
    assign C     = cf_q;
    assign N     = nf_q;
    assign Z     = zf_q;
    assign V     = vf_q;

endmodule

// File: tb/tb_shu_iter.sv
// Directed bench for shu_iter: a STEP=1 and a STEP=4 instance share the
// operand inputs; each scenario task checks latency, result and flags.
module tb_shu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [2:0]  op;
    logic [15:0] a;
    logic [7:0]  b;
    logic        cin;

    logic        rdy1, dn1, c1, n1, z1, v1;
    logic        rdy4, dn4, c4, n4, z4, v4;
    logic [15:0] s1, s4;

    logic        use4;
    logic        d_ready, d_done;
    logic [15:0] d_s;
    logic [3:0]  d_f;

    int total = 0;
    int bad   = 0;

    assign d_ready = use4 ? rdy4 : rdy1;
    assign d_done  = use4 ? dn4 : dn1;
    assign d_s     = use4 ? s4 : s1;
    assign d_f     = use4 ? {c4, n4, z4, v4} : {c1, n1, z1, v1};

    always #5 clk = ~clk;

    shu_iter #(.WIDTH(16), .STEP(1), .BW(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
        .cin(cin), .ready(rdy1), .done(dn1), .s(s1),
        .C(c1), .N(n1), .Z(z1), .V(v1)
    );

    shu_iter #(.WIDTH(16), .STEP(4), .BW(8)) u4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .b(b),
        .cin(cin), .ready(rdy4), .done(dn4), .s(s4),
        .C(c4), .N(n4), .Z(z4), .V(v4)
    );

    // Issue one op at a negedge, return cycles from start to done (-1 on timeout).
    task automatic run(input bit sel4, input logic [2:0] o,
                       input logic [15:0] av, input logic [7:0] bv,
                       input logic ci, output int lat);
        use4 = sel4;
        op   = o;
        a    = av;
        b    = bv;
        cin  = ci;
        if (sel4) start4 = 1'b1;
        else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        lat = 1;
        while (!d_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!d_done) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        use4 = 1'b0;
        op = 3'd0;
        a = 16'h0;
        b = 8'h0;
        cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy1, dn1, s1, c1, n1, z1, v1} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_u1 got rdy=%b done=%b s=%h f=%b want 1 0 0000 0000",
                     rdy1, dn1, s1, {c1, n1, z1, v1});
        end
        total++;
        if ({rdy4, dn4, s4, c4, n4, z4, v4} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_u4 got rdy=%b done=%b s=%h f=%b want 1 0 0000 0000",
                     rdy4, dn4, s4, {c4, n4, z4, v4});
        end
    endtask

    task automatic test_lsl;
        int lat;
        run(1'b0, 3'd0, 16'h8001, 8'd1, 1'b0, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL lsl_lat got %0d want 2", lat);
        end
        total++;
        if ({d_s, d_f} !== {16'h0002, 4'b1001}) begin
            bad++;
            $display("FAIL lsl_res got s=%h cnzv=%b want 0002 1001", d_s, d_f);
        end
    endtask

    task automatic test_asr_lsr;
        int lat;
        @(negedge clk);
        run(1'b1, 3'd2, 16'h8000, 8'd20, 1'b0, lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL asr_lat got %0d want 5", lat);
        end
        total++;
        if ({d_s, d_f} !== {16'hFFFF, 4'b1100}) begin
            bad++;
            $display("FAIL asr_res got s=%h cnzv=%b want ffff 1100", d_s, d_f);
        end
        @(negedge clk);
        run(1'b1, 3'd1, 16'hFFFF, 8'd17, 1'b1, lat);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL lsr17_lat got %0d want 6", lat);
        end
        total++;
        if ({d_s, d_f} !== {16'h0000, 4'b0011}) begin
            bad++;
            $display("FAIL lsr17_res got s=%h cnzv=%b want 0000 0011", d_s, d_f);
        end
    endtask

    task automatic test_rotate;
        int lat;
        @(negedge clk);
        run(1'b1, 3'd3, 16'h0001, 8'd17, 1'b0, lat);
        total++;
        if (lat !== 2 || {d_s, d_f} !== {16'h8000, 4'b1101}) begin
            bad++;
            $display("FAIL ror17 got lat=%0d s=%h cnzv=%b want 2 8000 1101",
                     lat, d_s, d_f);
        end
        @(negedge clk);
        run(1'b1, 3'd4, 16'h0001, 8'd1, 1'b1, lat);
        total++;
        if (lat !== 2 || {d_s, d_f} !== {16'h8000, 4'b1101}) begin
            bad++;
            $display("FAIL rrx1 got lat=%0d s=%h cnzv=%b want 2 8000 1101",
                     lat, d_s, d_f);
        end
        @(negedge clk);
        run(1'b1, 3'd4, 16'h0001, 8'd17, 1'b1, lat);
        total++;
        if (lat !== 1 || {d_s, d_f} !== {16'h0001, 4'b1000}) begin
            bad++;
            $display("FAIL rrx17 got lat=%0d s=%h cnzv=%b want 1 0001 1000",
                     lat, d_s, d_f);
        end
    endtask

    task automatic test_lnk_reserved;
        int lat;
        @(negedge clk);
        run(1'b0, 3'd7, 16'h7FFE, 8'd9, 1'b0, lat);
        total++;
        if (lat !== 1 || {d_s, d_f} !== {16'h8000, 4'b0101}) begin
            bad++;
            $display("FAIL lnk_7ffe got lat=%0d s=%h cnzv=%b want 1 8000 0101",
                     lat, d_s, d_f);
        end
        @(negedge clk);
        run(1'b0, 3'd7, 16'hFFFF, 8'd0, 1'b0, lat);
        total++;
        if (lat !== 1 || {d_s, d_f} !== {16'h0001, 4'b1000}) begin
            bad++;
            $display("FAIL lnk_ffff got lat=%0d s=%h cnzv=%b want 1 0001 1000",
                     lat, d_s, d_f);
        end
        @(negedge clk);
        run(1'b0, 3'd5, 16'h1234, 8'd3, 1'b1, lat);
        total++;
        if (lat !== 1 || {d_s, d_f} !== {16'h0000, 4'b0010}) begin
            bad++;
            $display("FAIL rsv5 got lat=%0d s=%h cnzv=%b want 1 0000 0010",
                     lat, d_s, d_f);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        @(negedge clk);
        use4 = 1'b0;
        op = 3'd1;
        a = 16'hF000;
        b = 8'd15;
        cin = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (dn1) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (rdy1 !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready got %b want 0", rdy1);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rdy1, dn1, s1, c1, n1, z1, v1} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            bad++;
            $display("FAIL midrst_state got rdy=%b done=%b s=%h f=%b want 1 0 0000 0000",
                     rdy1, dn1, s1, {c1, n1, z1, v1});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dn1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nodone got done=%b want 0", seen);
        end
        run(1'b0, 3'd1, 16'hF000, 8'd15, 1'b0, lat);
        total++;
        if (lat !== 16 || {d_s, d_f} !== {16'h0001, 4'b1001}) begin
            bad++;
            $display("FAIL after_rst got lat=%0d s=%h cnzv=%b want 16 0001 1001",
                     lat, d_s, d_f);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        run(1'b0, 3'd0, 16'h0003, 8'd2, 1'b0, lat);
        total++;
        if (lat !== 3 || {d_s, d_f} !== {16'h000C, 4'b0000}) begin
            bad++;
            $display("FAIL b2b_first got lat=%0d s=%h cnzv=%b want 3 000c 0000",
                     lat, d_s, d_f);
        end
        op = 3'd1;
        a = 16'h0100;
        b = 8'd3;
        cin = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        total++;
        if ({dn1, rdy1, s1} !== {1'b0, 1'b0, 16'h000C}) begin
            bad++;
            $display("FAIL b2b_accept got done=%b rdy=%b s=%h want 0 0 000c",
                     dn1, rdy1, s1);
        end
        op = 3'd7;
        a = 16'hFFFF;
        b = 8'd0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 2;
        total++;
        if ({dn1, s1} !== {1'b0, 16'h000C}) begin
            bad++;
            $display("FAIL busy_ignore got done=%b s=%h want 0 000c", dn1, s1);
        end
        while (!dn1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 4 || {s1, c1, n1, z1, v1} !== {16'h0020, 4'b0000}) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d s=%h cnzv=%b want 4 0020 0000",
                     lat, s1, {c1, n1, z1, v1});
        end
        @(negedge clk);
        total++;
        if ({dn1, rdy1, s1} !== {1'b0, 1'b1, 16'h0020}) begin
            bad++;
            $display("FAIL b2b_hold got done=%b rdy=%b s=%h want 0 1 0020",
                     dn1, rdy1, s1);
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr_lsr();
        test_rotate();
        test_lnk_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shu_iter.md
# shu_iter

Parametrised, multi-cycle shift unit for the ARM16 datapath, successor to the 4-bit combinational shifter. Performs LSL, LSR, ASR, ROR, RRX and LNK on a WIDTH-bit operand, shifting at most STEP bits per clock. Operands are accepted with a start/ready handshake; the result and the NZCV flags are registered and presented with a one-cycle `done` pulse. The block sits beside the ALU in the execute stage and stalls the pipeline via `ready`.

## Interface
- WIDTH, 16, operand/result width (≥4)
- STEP, 1, maximum bits shifted per cycle (power of two, 1..WIDTH)
- BW, 8, width of shift-amount input `b`
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when `ready`=1
- op  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5/6 reserved, 7 LNK
- a  in  WIDTH  operand
- b  in  BW  shift amount, unsigned
- cin  in  1  carry in
- ready  out  1  can accept `start` this cycle
- done  out  1  one-cycle pulse; result/flags valid
- s  out  WIDTH  result
- C, N, Z, V  out  1 each  flags

## Operation
- FSM states IDLE, SHIFT, DONE. `ready` = (IDLE or DONE).
- Accept (start & ready): latch a, op, cin into work regs `w`, `c`; compute remaining count n:
  - LSL, LSR: n = min(b, WIDTH+1); ASR: n = min(b, WIDTH)
  - ROR: n = b mod WIDTH; RRX: n = b mod (WIDTH+1)
  - LNK, reserved: n = 0
  - n = 0 → DONE next cycle; else → SHIFT.
- SHIFT: each cycle shift by k = min(STEP, n), n -= k; n reaching 0 → DONE.
  - LSL: c = last bit out of MSB, zero fill. LSR: c = last bit out of LSB, zero fill. ASR: as LSR, sign fill.
  - ROR: rotate w right by k; c = w[MSB] after rotate.
  - RRX: rotate {c,w} (WIDTH+1 bits) right by k.
- Entering DONE loads outputs: s = w (LNK: a+2 mod 2^WIDTH; reserved: 0).
  - C: shifts = c (equals cin when n=0 for all shift ops, incl. ROR); LNK = carry out of a+2; reserved = 0.
  - N = s[MSB]; Z = (s == 0).
  - V: shifts = a[MSB] ^ s[MSB]; LNK = signed overflow of a+2; reserved = 0.
- Outputs hold until the next result is loaded. `done` high exactly in DONE.
- start with ready=0 ignored; op/a/b/cin changes while busy have no effect.
- start in DONE accepted: back-to-back operations, no idle cycle.
- rst at any time: state IDLE, n cleared, in-flight op discarded, no `done`.

## Timing
- Reset values: ready=1, done=0, s=0, C=N=Z=V=0.
- Latency start → done = ceil(n/STEP) + 1 cycles; n=0 (incl. LNK) → 1 cycle.
- Throughput: one op per ceil(n/STEP)+1 cycles.
- Worst case: WIDTH+1 bits at STEP=1 → WIDTH+2 cycles.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package `shu_pkg`: op-code localparams (OP_LSL..OP_LNK), FSM state encoding, count-width function (clog2(WIDTH+2)).
- Sub-module `shu_step`: combinational one-pass shifter of {c,w} by k ≤ STEP for a given op; FSM, counter and flag logic in `shu_iter`.

## Test plan
- WIDTH=16, STEP=1: LSL a=0x8001 b=1 cin=0 → done 2 cycles after start, s=0x0002, C=1, N=0, Z=0, V=1.
- STEP=4: ASR a=0x8000 b=20 → n clamped 16, done 5 cycles after start, s=0xFFFF, C=1, N=1, V=0; LSR a=0xFFFF b=17 → s=0x0000, C=0, Z=1.
- ROR a=0x0001 b=17 → s=0x8000, C=1, N=1; RRX a=0x0001 cin=1 b=1 → s=0x8000, C=1; RRX b=17 → s=0x0001, C=1, done 1 cycle after start.
- LNK a=0x7FFE → done next cycle, s=0x8000, N=1, V=1, C=0; LNK a=0xFFFF → s=0x0001, C=1, V=0; op=5 → s=0, Z=1, C=N=V=0.
- STEP=1: LSR a=0xF000 b=15, rst asserted 5 cycles after start → ready=1 immediately, s=0, flags 0, no done; following op completes normally.
- Back-to-back: second start in DONE cycle of first → accepted, second done at its own latency; start during SHIFT → ignored, outputs unchanged.
